mac_seq: RTL and testbench

- Dot-product sequencer that sits directly downstream of the autoencoder's dual-read/single-write register memory and drives all three of its ports.
- On `start`, it streams two operand vectors (weights and activations) out of the memory through read ports 1 and 2, one element pair per cycle.
- It multiply-accumulates the pairs in signed fixed point, then rescales and saturates the sum.
- It writes the single neuron result back through the memory's write port.

---
 rtl/ae_pkg.sv | 16 +
 rtl/mac_seq_if.sv | 32 +++
 rtl/fxp_rescale_sat.sv | 26 ++
 rtl/mac_seq.sv | 93 +++++++++
 tb/tb_mac_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ae_pkg.sv
// ae_pkg: shared types and fixed-point helpers for the autoencoder datapath.
package ae_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

    localparam int DEF_FRAC_BITS = 8;

    function automatic longint sat_max(input int dw);
        return (longint'(1) << (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) << (dw - 1));
    endfunction

endpackage

// File: rtl/mac_seq_if.sv
// mac_seq_if: start/status handshake plus the dual-read/single-write memory ports.
// master is the sequencer side; slave is the requester/memory side.
interface mac_seq_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [ADDR_WIDTH:0]   length;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [ADDR_WIDTH-1:0] read_addr_1;
    logic [ADDR_WIDTH-1:0] read_addr_2;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  busy;
    logic                  done;
    logic                  saturated;

    modport master (
        input  start, base_a, base_b, length, dst_addr, read_data_1, read_data_2,
        output read_addr_1, read_addr_2, write_en, write_addr, write_data, busy, done, saturated
    );

    modport slave (
        output start, base_a, base_b, length, dst_addr, read_data_1, read_data_2,
        input  read_addr_1, read_addr_2, write_en, write_addr, write_data, busy, done, saturated
    );
endinterface

// File: rtl/fxp_rescale_sat.sv
// fxp_rescale_sat: arithmetic right shift by FRAC_BITS (floor), then clip to DATA_WIDTH signed range.
module fxp_rescale_sat
    import ae_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = 37
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic        [DATA_WIDTH-1:0] result,
    output logic                         sat
);
    localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [ACC_WIDTH-1:0] sh;
    logic hi, lo;

    always_comb begin
        sh     = acc >>> FRAC_BITS;
        hi     = sh > MAX_V;
        lo     = sh < MIN_V;
        sat    = hi || lo;
        result = hi ? MAX_V[DATA_WIDTH-1:0] : lo ? MIN_V[DATA_WIDTH-1:0] : sh[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/mac_seq.sv
// mac_seq: streams two vectors from memory, multiply-accumulates, rescales/saturates and writes one result.
// Optional MAC_SEQ_RELU_EN clamps negative results to zero (saturated still reports the pre-ReLU clip).
module mac_seq
    import ae_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH + 1
) (
    input logic      clk,
    input logic      rst_n,
    mac_seq_if.master bus
);
    state_t state_q, state_d;

    logic        [ADDR_WIDTH-1:0]   base_a_q, base_b_q, dst_q, idx_q;
    logic        [ADDR_WIDTH:0]     len_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic        [DATA_WIDTH-1:0]   rs_data, result;
    logic                           rs_sat, sat_q, last;

    assign prod = $signed(bus.read_data_1) * $signed(bus.read_data_2);
    assign last = {1'b0, idx_q} == len_q - 1'b1;

    fxp_rescale_sat #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_rescale (
        .acc   (acc_q),
        .result(rs_data),
        .sat   (rs_sat)
    );

`ifdef MAC_SEQ_RELU_EN
    assign result = rs_data[DATA_WIDTH-1] ? '0 : rs_data;
`else
    assign result = rs_data;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            base_a_q <= '0;
            base_b_q <= '0;
            dst_q    <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                dst_q <= bus.dst_addr;
                len_q <= bus.length;
                acc_q <= '0;
                // zero-length jobs leave base/idx alone so the read addresses keep their last value
                if (bus.length != '0) begin
                    base_a_q <= bus.base_a;
                    base_b_q <= bus.base_b;
                    idx_q    <= '0;
                end
            end
            if (state_q == ACCUM) begin
                acc_q <= acc_q + ACC_WIDTH'(prod);
                if (!last) idx_q <= idx_q + 1'b1;
            end
            if (state_q == WRITE) sat_q <= rs_sat;
        end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = bus.length == '0 ? WRITE : ACCUM;
            ACCUM:   if (last) state_d = WRITE;
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.read_addr_1 = base_a_q + idx_q;
        bus.read_addr_2 = base_b_q + idx_q;
        bus.busy        = state_q == ACCUM || state_q == WRITE;
        bus.write_en    = state_q == WRITE;
        bus.write_addr  = state_q == WRITE ? dst_q : '0;
        bus.write_data  = state_q == WRITE ? result : '0;
        bus.done        = state_q == DONE;
        bus.saturated   = state_q == DONE && sat_q;
    end
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed table-driven bench for mac_seq with a negedge-writing memory model.
module tb_mac_seq;
`ifdef MAC_SEQ_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct {
        logic [3:0]        ba, bb;
        logic [4:0]        len;
        logic [3:0]        dst;
        logic [0:3][15:0]  a, b;
        logic [15:0]       exp;
        logic              sat;
        int                dcyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    logic [15:0] mem [16];
    logic [15:0] img [16];
    logic [3:0]  seq [16];
    logic [3:0]  pre_addr, got_waddr;
    logic [15:0] got_data;
    logic        got_sat;
    int          we_cnt, acc_cyc, done_cyc, got_busy;
    int          npass = 0, ntot = 0;
    vec_t        v [7];

    always #5 clk = ~clk;

    mac_seq_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

    mac_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.read_data_1 = mem[bus.read_addr_1];
    assign bus.read_data_2 = mem[bus.read_addr_2];

    always @(negedge clk)
        if (load) mem <= img;
        else if (bus.write_en) mem[bus.write_addr] <= bus.write_data;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic load_mem();
        @(posedge clk); #1 load = 1'b1;
        @(negedge clk); #1 load = 1'b0;
    endtask

    task automatic build_img(input int k);
        for (int i = 0; i < 16; i++) img[i] = 16'h0000;
        img[v[k].dst] = 16'hABCD;
        for (int i = 0; i < 4 && i < int'(v[k].len); i++) begin
            img[4'(v[k].ba + i)] = v[k].a[i];
            img[4'(v[k].bb + i)] = v[k].b[i];
        end
    endtask

    task automatic run_op(input logic [3:0] ba, bb, input logic [4:0] len, input logic [3:0] dst,
                          input int poke);
        @(posedge clk); #1;
        pre_addr     = bus.read_addr_1;
        bus.start    = 1'b1;
        bus.base_a   = ba;
        bus.base_b   = bb;
        bus.length   = len;
        bus.dst_addr = dst;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.base_a = ~ba;
        bus.length = 5'd3;
        we_cnt = 0; acc_cyc = 0; done_cyc = 0; got_sat = 1'b0; got_busy = 0;
        got_data = 16'hDEAD; got_waddr = 4'hF;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.busy && !bus.write_en && acc_cyc < 16) begin
                seq[acc_cyc] = bus.read_addr_1;
                acc_cyc++;
            end
            if (bus.write_en) begin
                we_cnt++;
                got_data  = bus.write_data;
                got_waddr = bus.write_addr;
            end
            if (bus.done) begin
                done_cyc = c;
                got_sat  = bus.saturated;
                got_busy = int'(bus.busy);
            end
            if (c == poke) begin
                #1 bus.start = 1'b1; bus.base_a = 4'd0; bus.length = 5'd1;
                @(posedge clk); #1 bus.start = 1'b0;
            end
            if (done_cyc != 0) break;
        end
    endtask

    task automatic check_op(input string nm, input logic [3:0] ba, input logic [4:0] len,
                            input logic [3:0] dst, input logic [15:0] exp, input logic sat,
                            input int dcyc);
        check({nm, " done_cycle"}, done_cyc, dcyc);
        check({nm, " write_data"}, got_data, exp);
        check({nm, " saturated"}, got_sat, sat);
        check({nm, " write_pulses"}, we_cnt, 1);
        check({nm, " write_addr"}, got_waddr, dst);
        check({nm, " mem_dst"}, mem[dst], exp);
        check({nm, " accum_cycles"}, acc_cyc, len);
        check({nm, " busy_at_done"}, got_busy, 0);
        for (int i = 0; i < int'(len) && i < 16; i++)
            check($sformatf("%s read_addr_1[%0d]", nm, i), seq[i], 4'(ba + i));
        check({nm, " addr_hold"}, bus.read_addr_1, len == 0 ? pre_addr : 4'(ba + len - 1));
    endtask

    task automatic run_vec(input int k, input int poke);
        build_img(k);
        load_mem();
        run_op(v[k].ba, v[k].bb, v[k].len, v[k].dst, poke);
        check_op($sformatf("v%0d", k), v[k].ba, v[k].len, v[k].dst, v[k].exp, v[k].sat, v[k].dcyc);
    endtask

    initial begin
        bus.start = 1'b0; bus.base_a = '0; bus.base_b = '0; bus.length = '0; bus.dst_addr = '0;
        for (int i = 0; i < 16; i++) img[i] = 16'h0000;

        v[0] = '{ba: 4'd0, bb: 4'd8, len: 5'd4, dst: 4'd12,
                 a: '{16'h0100, 16'h0200, 16'hFF00, 16'h0080},
                 b: '{16'h0100, 16'h0100, 16'h0100, 16'h0200},
                 exp: 16'h0300, sat: 1'b0, dcyc: 6};
        v[1] = '{ba: 4'd0, bb: 4'd2, len: 5'd2, dst: 4'd5,
                 a: '{16'h7FFF, 16'h7FFF, 16'h0, 16'h0}, b: '{16'h7FFF, 16'h7FFF, 16'h0, 16'h0},
                 exp: 16'h7FFF, sat: 1'b1, dcyc: 4};
        v[2] = '{ba: 4'd0, bb: 4'd2, len: 5'd2, dst: 4'd5,
                 a: '{16'h8001, 16'h8001, 16'h0, 16'h0}, b: '{16'h7FFF, 16'h7FFF, 16'h0, 16'h0},
                 exp: RELU ? 16'h0000 : 16'h8000, sat: 1'b1, dcyc: 4};
        v[3] = '{ba: 4'd3, bb: 4'd7, len: 5'd1, dst: 4'd10,
                 a: '{16'hFF00, 16'h0, 16'h0, 16'h0}, b: '{16'h0100, 16'h0, 16'h0, 16'h0},
                 exp: RELU ? 16'h0000 : 16'hFF00, sat: 1'b0, dcyc: 3};
        v[4] = '{ba: 4'd14, bb: 4'd4, len: 5'd4, dst: 4'd9,
                 a: '{16'h0100, 16'h0100, 16'h0100, 16'h0100},
                 b: '{16'h0100, 16'h0200, 16'h0300, 16'h0400},
                 exp: 16'h0A00, sat: 1'b0, dcyc: 6};
        v[5] = '{ba: 4'd2, bb: 4'd3, len: 5'd0, dst: 4'd11,
                 a: '{16'h0, 16'h0, 16'h0, 16'h0}, b: '{16'h0, 16'h0, 16'h0, 16'h0},
                 exp: 16'h0000, sat: 1'b0, dcyc: 2};
        v[6] = '{ba: 4'd0, bb: 4'd1, len: 5'd1, dst: 4'd2,
                 a: '{16'hFFFF, 16'h0, 16'h0, 16'h0}, b: '{16'h0001, 16'h0, 16'h0, 16'h0},
                 exp: RELU ? 16'h0000 : 16'hFFFF, sat: 1'b0, dcyc: 3};

        #1;
        check("reset outputs",
              {bus.busy, bus.done, bus.write_en, bus.saturated, bus.read_addr_1, bus.read_addr_2,
               bus.write_addr, bus.write_data}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_vec(k, 0);

        // start pulsed mid-ACCUM must not disturb the running job
        run_vec(0, 2);

        // full-length job covering every address, dst overlapping the operands
        for (int i = 0; i < 16; i++) img[i] = 16'h0100;
        load_mem();
        run_op(4'd0, 4'd0, 5'd16, 4'd5, 0);
        check_op("full16", 4'd0, 5'd16, 4'd5, 16'h1000, 1'b0, 18);

        // reset in the second ACCUM cycle: outputs drop at once, no write happens
        build_img(0);
        load_mem();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_a = 4'd0; bus.base_b = 4'd8; bus.length = 5'd4; bus.dst_addr = 4'd12;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check("midreset outputs", {bus.busy, bus.write_en, bus.done}, 32'h0);
        repeat (6) @(negedge clk);
        check("midreset mem_dst", mem[12], 16'hABCD);
        rst_n = 1'b1;
        run_vec(0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
